// File: rtl/ring_cnt_pkg.sv
// ring_cnt_pkg: shared constants and legality helpers for the ring/Johnson counter.
//   MODE_RING / MODE_JOHNSON : values of the mode input
//   DIR_UP / DIR_DN          : values of the dir input (toward MSB / toward LSB)
//   ring_legal()             : exactly one bit set
//   johnson_legal()          : at most one differing adjacent bit pair within w bits
// Both helpers take a 32-bit zero-extended value, so any WIDTH in 2..32 fits.
package ring_cnt_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DN       = 1'b1;

  function automatic logic ring_legal(logic [31:0] v);
    return $countones(v) == 1;
  endfunction

  // Only pairs (i, i+1) with i + 1 < w are inspected; bits above w are ignored.
  function automatic logic johnson_legal(logic [31:0] v, int unsigned w);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((i + 1 < w) && (v[i] != v[i+1])) cnt++;
    end
    return cnt <= 1;
  endfunction

endpackage

// File: rtl/ring_cnt_multi_if.sv
// ring_cnt_multi_if: control and status bundle of the ring/Johnson counter.
//   in       : advance enable
//   mode     : 0 ring, 1 Johnson
//   dir      : 0 toward MSB, 1 toward LSB
//   load     : load strobe, load_val : value to load
//   result   : counter state, wrap : return-to-seed pulse, err : error pulse
// master drives the controls, slave (the counter) drives the status.
interface ring_cnt_multi_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in;
  logic             mode;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] result;
  logic             wrap;
  logic             err;

  modport master (
    output in, mode, dir, load, load_val,
    input  result, wrap, err
  );

  modport slave (
    input  in, mode, dir, load, load_val,
    output result, wrap, err
  );
endinterface

// File: rtl/ring_cnt_chk.sv
// ring_cnt_chk: combinational legality check of a WIDTH-bit counter word.
//   value      : word under test
//   ring_ok    : value is a legal ring state (one-hot)
//   johnson_ok : value is a legal Johnson state
module ring_cnt_chk
  import ring_cnt_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] value,
  output logic             ring_ok,
  output logic             johnson_ok
);
  logic [31:0] value_ext;

  assign value_ext  = 32'(value);
  assign ring_ok    = ring_legal(value_ext);
  assign johnson_ok = johnson_legal(value_ext, WIDTH);
endmodule

// File: rtl/ring_cnt_multi.sv
// ring_cnt_multi: WIDTH-bit ring (one-hot) / Johnson counter with load and upset recovery.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : ring_cnt_multi_if.slave (in, mode, dir, load, load_val -> result, wrap, err)
// Per-edge priority: rst > load > mode change > illegal-state recovery > advance > hold.
module ring_cnt_multi
  import ring_cnt_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  ring_cnt_multi_if.slave bus
);
  logic [WIDTH-1:0] result_q, result_d;
  logic             mode_q, mode_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] adv;
  logic             res_ring_ok, res_john_ok;
  logic             ld_ring_ok, ld_john_ok;
  logic             res_legal, ld_legal;

  function automatic logic [WIDTH-1:0] seed_of(logic m);
    return (m == MODE_JOHNSON) ? '0 : WIDTH'(1);
  endfunction

  ring_cnt_chk #(.WIDTH(WIDTH)) u_chk_result (
    .value      (result_q),
    .ring_ok    (res_ring_ok),
    .johnson_ok (res_john_ok)
  );

  ring_cnt_chk #(.WIDTH(WIDTH)) u_chk_load (
    .value      (bus.load_val),
    .ring_ok    (ld_ring_ok),
    .johnson_ok (ld_john_ok)
  );

  // State legality follows the registered mode; load legality follows the mode input.
  assign res_legal = (mode_q == MODE_JOHNSON) ? res_john_ok : res_ring_ok;
  assign ld_legal  = (bus.mode == MODE_JOHNSON) ? ld_john_ok : ld_ring_ok;

  always_comb begin
    adv = result_q;
    if (bus.dir == DIR_UP) begin
      adv = {result_q[WIDTH-2:0],
             (mode_q == MODE_JOHNSON) ? ~result_q[WIDTH-1] : result_q[WIDTH-1]};
    end else begin
      adv = {(mode_q == MODE_JOHNSON) ? ~result_q[0] : result_q[0],
             result_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    result_d = result_q;
    mode_d   = mode_q;
    wrap_d   = 1'b0;
    err_d    = 1'b0;
    if (bus.load) begin
      mode_d = bus.mode;
      if (ld_legal) begin
        result_d = bus.load_val;
      end else begin
        result_d = seed_of(bus.mode);
        err_d    = 1'b1;
      end
    end else if (bus.mode != mode_q) begin
      mode_d   = bus.mode;
      result_d = seed_of(bus.mode);
    end else if (!res_legal) begin
      result_d = seed_of(mode_q);
      err_d    = 1'b1;
    end else if (bus.in) begin
      result_d = adv;
      wrap_d   = (adv == seed_of(mode_q));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= seed_of(bus.mode);
      mode_q   <= bus.mode;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      mode_q   <= mode_d;
      wrap_q   <= wrap_d;
      err_q    <= err_d;
    end
  end

  assign bus.result = result_q;
  assign bus.wrap   = wrap_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_ring_cnt_multi.sv
// tb_ring_cnt_multi: directed self-checking bench for ring_cnt_multi at WIDTH=4.
module tb_ring_cnt_multi;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  ring_cnt_multi_if #(.WIDTH(4)) bus ();

  ring_cnt_multi #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; outputs are then sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [3:0] exp_res, input logic exp_wrap,
                     input logic exp_err);
    total++;
    assert (bus.result === exp_res) else begin
      bad++;
      $error("FAIL %s result=%b expected=%b", tag, bus.result, exp_res);
    end
    total++;
    assert (bus.wrap === exp_wrap) else begin
      bad++;
      $error("FAIL %s wrap=%b expected=%b", tag, bus.wrap, exp_wrap);
    end
    total++;
    assert (bus.err === exp_err) else begin
      bad++;
      $error("FAIL %s err=%b expected=%b", tag, bus.err, exp_err);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    bus.in = 1'b0;
    bus.mode = 1'b0;
    bus.dir = 1'b0;
    bus.load = 1'b0;
    bus.load_val = 4'b0000;

    // Ring, dir up
    step(); chk("ring_rst", 4'b0001, 1'b0, 1'b0);
    rst = 1'b0; bus.in = 1'b1;
    step(); chk("ring_a1", 4'b0010, 1'b0, 1'b0);
    step(); chk("ring_a2", 4'b0100, 1'b0, 1'b0);
    step(); chk("ring_a3", 4'b1000, 1'b0, 1'b0);
    step(); chk("ring_wrap", 4'b0001, 1'b1, 1'b0);
    step(); chk("ring_a5", 4'b0010, 1'b0, 1'b0);

    // Johnson, dir up, from reset
    rst = 1'b1; bus.mode = 1'b1; bus.in = 1'b0;
    step(); chk("john_rst", 4'b0000, 1'b0, 1'b0);
    rst = 1'b0; bus.in = 1'b1;
    step(); chk("john_a1", 4'b0001, 1'b0, 1'b0);
    step(); chk("john_a2", 4'b0011, 1'b0, 1'b0);
    step(); chk("john_a3", 4'b0111, 1'b0, 1'b0);
    step(); chk("john_a4", 4'b1111, 1'b0, 1'b0);
    step(); chk("john_a5", 4'b1110, 1'b0, 1'b0);
    step(); chk("john_a6", 4'b1100, 1'b0, 1'b0);
    step(); chk("john_a7", 4'b1000, 1'b0, 1'b0);
    step(); chk("john_wrap", 4'b0000, 1'b1, 1'b0);

    // Johnson, dir down
    bus.dir = 1'b1;
    step(); chk("john_dn1", 4'b1000, 1'b0, 1'b0);
    step(); chk("john_dn2", 4'b1100, 1'b0, 1'b0);

    // Johnson loads: legal, then illegal
    bus.load = 1'b1; bus.load_val = 4'b0011;
    step(); chk("john_ld_ok", 4'b0011, 1'b0, 1'b0);
    bus.load_val = 4'b0101;
    step(); chk("john_ld_bad", 4'b0000, 1'b0, 1'b1);

    // Ring, dir down, then hold
    bus.load = 1'b0; rst = 1'b1; bus.mode = 1'b0; bus.in = 1'b0;
    step(); chk("ringdn_rst", 4'b0001, 1'b0, 1'b0);
    rst = 1'b0; bus.dir = 1'b1; bus.in = 1'b1;
    step(); chk("ringdn_a1", 4'b1000, 1'b0, 1'b0);
    step(); chk("ringdn_a2", 4'b0100, 1'b0, 1'b0);
    bus.in = 1'b0;
    step(); chk("hold1", 4'b0100, 1'b0, 1'b0);
    step(); chk("hold2", 4'b0100, 1'b0, 1'b0);
    step(); chk("hold3", 4'b0100, 1'b0, 1'b0);

    // Ring loads
    bus.dir = 1'b0; bus.in = 1'b1; bus.load = 1'b1; bus.load_val = 4'b0100;
    step(); chk("ring_ld_ok", 4'b0100, 1'b0, 1'b0);
    bus.load_val = 4'b0110;
    step(); chk("ring_ld_bad", 4'b0001, 1'b0, 1'b1);
    bus.load = 1'b0; bus.in = 1'b0;
    step(); chk("err_clear", 4'b0001, 1'b0, 1'b0);

    // Mode switch mid-count, then rst beating load/in
    bus.in = 1'b1;
    step(); chk("pre_sw1", 4'b0010, 1'b0, 1'b0);
    step(); chk("pre_sw2", 4'b0100, 1'b0, 1'b0);
    bus.mode = 1'b1;
    step(); chk("mode_sw", 4'b0000, 1'b0, 1'b0);
    rst = 1'b1; bus.load = 1'b1; bus.load_val = 4'b0011;
    step(); chk("rst_vs_ld", 4'b0000, 1'b0, 1'b0);
    rst = 1'b0; bus.load = 1'b0;
    step(); chk("post_rst", 4'b0001, 1'b0, 1'b0);

    // Load that also switches mode back to ring
    bus.load = 1'b1; bus.mode = 1'b0; bus.load_val = 4'b1000;
    step(); chk("ld_modesw", 4'b1000, 1'b0, 1'b0);
    bus.load = 1'b0;
    step(); chk("ld_modesw_adv", 4'b0001, 1'b1, 1'b0);

    // Upset recovery: illegal state injected into the register
    step(); chk("pre_upset", 4'b0010, 1'b0, 1'b0);
    force dut.result_q = 4'b0101;
    #1;
    release dut.result_q;
    step(); chk("upset_fix", 4'b0001, 1'b0, 1'b1);
    step(); chk("upset_resume", 4'b0010, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ring_cnt_multi.md
RING_CNT_MULTI -- requirements
Module: ring_cnt_multi

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the counter bit count; legal range 2..32.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in  input  1  advance enable; the counter steps one position per cycle while high.
REQ-005 SHALL have port mode  input  1  0 = ring (one-hot), 1 = Johnson (twisted-ring).
REQ-006 SHALL have port dir  input  1  0 = shift toward MSB, 1 = shift toward LSB.
REQ-007 SHALL have port load  input  1  synchronous load strobe.
REQ-008 SHALL have port load_val  input  WIDTH  value applied on load.
REQ-009 SHALL have port result  output  WIDTH  registered counter state.
REQ-010 SHALL have port wrap  output  1  registered one-cycle pulse on return to seed.
REQ-011 SHALL have port err  output  1  registered one-cycle pulse on rejected load or illegal state.

Function
REQ-012 SHALL define the seed as WIDTH'b1 for ring mode and all-zeros for Johnson mode.
REQ-013 SHALL apply per-cycle priority: rst > load > mode change > illegal-state recovery > advance > hold.
REQ-014 Ring advance SHALL follow the mapping below.
- dir=0: result <= {result[W-2:0], result[W-1]}.
- dir=1: result <= {result[0], result[W-1:1]}.
REQ-015 Johnson advance SHALL follow the mapping below.
- dir=0: result <= {result[W-2:0], ~result[W-1]}.
- dir=1: result <= {~result[0], result[W-1:1]}.
REQ-016 SHALL give a period of WIDTH advances in ring mode and 2*WIDTH in Johnson mode.
REQ-017 SHALL register mode internally (mode_q).
- mode != mode_q without load: result reseeds to the new mode's seed on that edge, mode_q updates, in is ignored.
REQ-018 Load SHALL accept load_val only if legal for the current mode input.
- Ring legal: exactly one bit set.
- Johnson legal: at most one differing adjacent pair among bits [i], [i+1] for i = 0..W-2.
REQ-019 Illegal load_val SHALL reseed result to the current mode's seed, with err=1 on the following cycle.
- mode_q updates on any load, legal or not.
REQ-020 SHALL, when not loading, reseed on the next edge if result is illegal for mode_q (upset recovery), with err=1 on the following cycle.
REQ-021 wrap SHALL be 1 for exactly the cycle in which result equals seed as a consequence of an advance.
- wrap SHALL stay 0 after reset, load, reseed or hold.
REQ-022 in=0 SHALL hold result; dir changes take effect on the next advance without reseeding.
REQ-023 err and wrap SHALL never be sticky; each deasserts after one cycle unless re-triggered.

Reset
REQ-024 rst=1 at an edge SHALL set the outputs and mode_q as follows.
- result <= seed of the mode input.
- mode_q <= mode.
- wrap <= 0, err <= 0.
REQ-025 rst mid-count SHALL override load, in and mode change on the same edge; counting resumes from seed the cycle after rst falls.

Structure
REQ-026 Package ring_cnt_pkg SHALL hold the MODE_RING/MODE_JOHNSON and DIR_UP/DIR_DN constants and the legality-check functions.
REQ-027 Legality checking SHALL be one sub-module, ring_cnt_chk (combinational, WIDTH-parametrised, outputs ring_ok and johnson_ok), instanced twice: once for result, once for load_val.

Verification
REQ-028 Ring, dir=0, W=4: rst then in=1 for 5 cycles -> result 0001,0010,0100,1000,0001; wrap=1 only on the final 0001.
REQ-029 Johnson, dir=0, W=4: in=1 for 8 cycles from reset -> 0001,0011,0111,1111,1110,1100,1000,0000; wrap=1 on 0000 only.
REQ-030 Ring, dir=1, W=4: from 0001 advance twice -> 1000, 0100; then in=0 for 3 cycles -> holds 0100, wrap=0.
REQ-031 Ring load: load_val=0100 with in=1 -> result 0100, err=0; load_val=0110 -> result 0001, err=1 for one cycle.
REQ-032 Mode switch at result=0100 with in=1 -> 0000 next edge, wrap=0; then rst=1 with load=1 and in=1 -> seed of mode, err=0, wrap=0.
REQ-033 Force result to 0101 in ring mode -> 0001 next edge, err=1 one cycle later, normal counting resumes.
